arbitro_memoria_tabuleiro: RTL and testbench
============================================

# arbitro_memoria_tabuleiro

Parametrised arbiter between the game's functional blocks (validador, colisor, pontuacao, VGA) and the per-player board memories. It replaces ad-hoc state steering with an explicit request/grant handshake, a fixed-priority arbiter and a response path with a read-valid strobe. Player count, address/data width and memory read latency are configurable. It sits between the game-logic blocks and the N_JOGADORES synchronous RAM banks.

## Interface
- N_JOGADORES, 2: number of player board banks (≥1); JW = max(1, clog2(N_JOGADORES))
- ADDR_W, 5: board row address width
- DATA_W, 64: board row width
- RD_LAT, 1: memory read latency in cycles (1..4)
- MAX_ESPERA, 4: VGA starvation limit, in lost arbitration decisions (used only with the macro)

Ports:
- clk  in  1  system clock
- resetGeral  in  1  reset; synchronous, active-high
- val_req, col_req  in  1  request, held until grant
- val_we, col_we  in  1  write request (0 = read)
- val_jogador, col_jogador, pts_jogador, vga_jogador  in  JW  target bank
- val_addr, col_addr, pts_addr, vga_addr  in  ADDR_W  row address
- val_wdata, col_wdata  in  DATA_W  write data
- pts_req, vga_req  in  1  read-only requests
- val_gnt, col_gnt, pts_gnt, vga_gnt  out  1  one-cycle grant
- val_rvalid, col_rvalid, pts_rvalid, vga_rvalid  out  1  one-cycle read-data-valid
- val_rdata, col_rdata, pts_rdata, vga_rdata  out  DATA_W  read data, held until next rvalid for that client
- mem_rdata  in  N_JOGADORES*DATA_W  bank q outputs; bank k at [k*DATA_W +: DATA_W]
- mem_addr  out  ADDR_W  shared address
- mem_wdata  out  DATA_W  shared write data
- mem_wren  out  N_JOGADORES  per-bank write enable, at most one bit high

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: when any req is high, the arbiter picks a winner at the clock edge and moves to ISSUE. Priority: val > col > pts > vga.
- ISSUE (1 cycle):
  - Winner's gnt = 1.
  - mem_addr, mem_wdata and mem_wren are registered from the winner's fields.
  - mem_wren[jogador] = we; the other bits are 0.
  - After a write, go to IDLE. After a read, go to WAIT.
- WAIT: RD_LAT cycles, counted down. On the last cycle, capture mem_rdata slice [jogador] and go to RESP.
- RESP (1 cycle): winner's rvalid = 1 and rdata is updated. Next state is IDLE.
- Out-of-range jogador (≥ N_JOGADORES):
  - Grant is still issued.
  - No mem_wren bit is set.
  - A read returns rdata = 0 with rvalid.
- Client rules:
  - Fields must be stable from req rise through the gnt cycle.
  - req may drop the cycle after gnt.
  - req still high in the cycle after gnt is a new request.
  - A client dropping req before gnt is withdrawn without side effects.
- Only one transaction is in flight. Requests arriving during ISSUE/WAIT/RESP wait until IDLE.
- Reset values: state IDLE, all gnt/rvalid/mem_wren = 0, mem_addr/mem_wdata = 0, all rdata = 0, starvation counter = 0.
- Reset mid-operation:
  - An in-flight read is discarded; no rvalid.
  - A write whose ISSUE cycle coincides with reset high still commits, because mem_wren is already registered. Nothing is issued after that.

## Timing
- Read: req sampled at edge 0 → gnt and mem_addr in cycle 1 → rvalid/rdata in cycle 2+RD_LAT.
- Write: gnt and mem_wren in cycle 1; memory written at the end of cycle 1.
- Throughput: one read per 3+RD_LAT cycles; one write per 2 cycles.
- Simultaneous requests: only the winner is granted; the others keep req high and are re-arbitrated in the next IDLE.

## Configuration
- ARBITRO_MEM_ANTI_INANICAO_EN defined:
  - A counter increments each time vga_req is high at an arbitration decision that VGA loses.
  - When the counter reaches MAX_ESPERA, VGA wins the next decision regardless of priority.
  - The counter clears when VGA is granted or vga_req is low.
- Undefined: pure fixed priority; VGA can starve indefinitely.

## Test plan
- Reset behaviour: resetGeral=1 for 2 cycles → all outputs 0, FSM in IDLE.
- Single write then read:
  - col write, jogador=1, addr=5, data=64'hA5 → mem_wren=2'b10 in cycle 1.
  - Subsequent col read of the same location, RD_LAT=1 → col_rvalid in cycle 3 with rdata=64'hA5.
- Priority: val read and vga read raised in the same cycle → val_gnt first. vga_gnt follows after val's RESP, with no overlap.
- Out-of-range bank: N_JOGADORES=2, pts read with jogador wider build (N_JOGADORES=3, jogador=3 on JW=2) → mem_wren=0, pts_rdata=0, pts_rvalid=1.
- Starvation guard (macro defined, MAX_ESPERA=4): val_req held high continuously alongside vga_req → vga_gnt on the 5th decision. With the macro undefined, vga_gnt never occurs.
- Reset mid-read: resetGeral pulsed during WAIT → no rvalid, next request serviced normally from IDLE.

Source files
------------

// File: rtl/arbitro_memoria_tabuleiro_if.sv
// Client/memory bundle for arbitro_memoria_tabuleiro.
// slave  : arbiter side (takes requests and bank q data, drives grants, responses and the memory bus)
// master : client/memory side
interface arbitro_memoria_tabuleiro_if #(
  parameter int N_JOGADORES = 2,
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 64
);
  localparam int JW = (N_JOGADORES > 1) ? $clog2(N_JOGADORES) : 1;

  logic                          val_req, col_req, pts_req, vga_req;
  logic                          val_we, col_we;
  logic [JW-1:0]                 val_jogador, col_jogador, pts_jogador, vga_jogador;
  logic [ADDR_W-1:0]             val_addr, col_addr, pts_addr, vga_addr;
  logic [DATA_W-1:0]             val_wdata, col_wdata;
  logic                          val_gnt, col_gnt, pts_gnt, vga_gnt;
  logic                          val_rvalid, col_rvalid, pts_rvalid, vga_rvalid;
  logic [DATA_W-1:0]             val_rdata, col_rdata, pts_rdata, vga_rdata;
  logic [N_JOGADORES*DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0]             mem_addr;
  logic [DATA_W-1:0]             mem_wdata;
  logic [N_JOGADORES-1:0]        mem_wren;

  modport slave (
    input  val_req, col_req, pts_req, vga_req, val_we, col_we,
           val_jogador, col_jogador, pts_jogador, vga_jogador,
           val_addr, col_addr, pts_addr, vga_addr, val_wdata, col_wdata, mem_rdata,
    output val_gnt, col_gnt, pts_gnt, vga_gnt,
           val_rvalid, col_rvalid, pts_rvalid, vga_rvalid,
           val_rdata, col_rdata, pts_rdata, vga_rdata,
           mem_addr, mem_wdata, mem_wren
  );

  modport master (
    output val_req, col_req, pts_req, vga_req, val_we, col_we,
           val_jogador, col_jogador, pts_jogador, vga_jogador,
           val_addr, col_addr, pts_addr, vga_addr, val_wdata, col_wdata, mem_rdata,
    input  val_gnt, col_gnt, pts_gnt, vga_gnt,
           val_rvalid, col_rvalid, pts_rvalid, vga_rvalid,
           val_rdata, col_rdata, pts_rdata, vga_rdata,
           mem_addr, mem_wdata, mem_wren
  );
endinterface

// File: rtl/arbitro_memoria_tabuleiro.sv
// Fixed-priority arbiter (val > col > pts > vga) between the game blocks and the
// per-player board RAM banks. One transaction in flight: IDLE -> ISSUE -> [WAIT -> RESP].
// Optional VGA anti-starvation guard: define ARBITRO_MEM_ANTI_INANICAO_EN.

// Per-client response slot: one-cycle rvalid strobe and held read data.
module arbitro_memoria_tabuleiro_slot #(
  parameter int DATA_W = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_rvalid,
  output logic [DATA_W-1:0] o_rdata
);
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;

  // strobe for one cycle on load; data stays until the next load
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= i_load;
      if (i_load) r_rdata <= i_data;
    end
  end

  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;
endmodule

module arbitro_memoria_tabuleiro #(
  parameter int N_JOGADORES = 2,
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 64,
  parameter int RD_LAT      = 1,
  parameter int MAX_ESPERA  = 4
) (
  input logic                        clk,
  input logic                        resetGeral,
  arbitro_memoria_tabuleiro_if.slave bus
);
  localparam int JW = (N_JOGADORES > 1) ? $clog2(N_JOGADORES) : 1;
  localparam int NC = 4;  // client index: 0 val, 1 col, 2 pts, 3 vga

  if (N_JOGADORES < 1 || RD_LAT < 1 || RD_LAT > 4 || MAX_ESPERA < 1) begin : g_bad_cfg
    $error("arbitro_memoria_tabuleiro: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} estado_t;

  estado_t                         r_estado, w_prox;
  logic [1:0]                      r_win, w_win;
  logic                            r_we;
  logic [JW-1:0]                   r_jog;
  logic [2:0]                      r_cnt;
  logic [NC-1:0]                   r_gnt;
  logic [ADDR_W-1:0]               r_mem_addr;
  logic [DATA_W-1:0]               r_mem_wdata;
  logic [N_JOGADORES-1:0]          r_mem_wren, w_wren;

  logic [NC-1:0]                   w_req, w_we, w_load, w_rvalid;
  logic [NC-1:0][JW-1:0]           w_jog;
  logic [NC-1:0][ADDR_W-1:0]       w_addr;
  logic [NC-1:0][DATA_W-1:0]       w_wdata, w_rdata;
  logic [DATA_W-1:0]               w_cap;
  logic                            w_any, w_force_vga, w_ultimo;

  // pts and vga are read-only clients
  assign w_req   = {bus.vga_req, bus.pts_req, bus.col_req, bus.val_req};
  assign w_we    = {1'b0, 1'b0, bus.col_we, bus.val_we};
  assign w_jog   = {bus.vga_jogador, bus.pts_jogador, bus.col_jogador, bus.val_jogador};
  assign w_addr  = {bus.vga_addr, bus.pts_addr, bus.col_addr, bus.val_addr};
  assign w_wdata = {{DATA_W{1'b0}}, {DATA_W{1'b0}}, bus.col_wdata, bus.val_wdata};
  assign w_any   = |w_req;

`ifdef ARBITRO_MEM_ANTI_INANICAO_EN
  localparam int EW = $clog2(MAX_ESPERA + 1);
  logic [EW-1:0] r_espera;

  assign w_force_vga = bus.vga_req && (32'(r_espera) == MAX_ESPERA);

  // count decisions VGA loses while requesting; clear on VGA win or idle request
  always_ff @(posedge clk) begin
    if (resetGeral || !bus.vga_req) r_espera <= '0;
    else if (r_estado == IDLE && w_any) begin
      if (w_win == 2'd3)                       r_espera <= '0;
      else if (32'(r_espera) != MAX_ESPERA)    r_espera <= r_espera + EW'(1);
    end
  end
`else
  assign w_force_vga = 1'b0;
`endif

  // winner selection: guard override first, then fixed priority
  always_comb begin
    w_win = 2'd3;
    if (w_force_vga)   w_win = 2'd3;
    else if (w_req[0]) w_win = 2'd0;
    else if (w_req[1]) w_win = 2'd1;
    else if (w_req[2]) w_win = 2'd2;
  end

  // one-hot bank write enable; out-of-range bank leaves it all-zero
  always_comb begin
    w_wren = '0;
    for (int k = 0; k < N_JOGADORES; k++)
      if (w_we[w_win] && 32'(w_jog[w_win]) == k) w_wren[k] = 1'b1;
  end

  // select the addressed bank's q; out-of-range bank reads as zero
  always_comb begin
    w_cap = '0;
    for (int k = 0; k < N_JOGADORES; k++)
      if (32'(r_jog) == k) w_cap = bus.mem_rdata[k*DATA_W +: DATA_W];
  end

  // state register
  always_ff @(posedge clk) begin
    if (resetGeral) r_estado <= IDLE;
    else            r_estado <= w_prox;
  end

  // next-state logic
  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      IDLE:    if (w_any) w_prox = ISSUE;
      ISSUE:   w_prox = r_we ? IDLE : WAIT;
      WAIT:    if (r_cnt == 3'd0) w_prox = RESP;
      RESP:    w_prox = IDLE;
      default: w_prox = IDLE;
    endcase
  end

  // latch the winner's request and drive the registered memory bus and grant
  always_ff @(posedge clk) begin
    if (resetGeral) begin
      r_win       <= '0;
      r_we        <= 1'b0;
      r_jog       <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wren  <= '0;
    end else begin
      r_gnt      <= '0;
      r_mem_wren <= '0;
      case (r_estado)
        IDLE: if (w_any) begin
          r_win        <= w_win;
          r_we         <= w_we[w_win];
          r_jog        <= w_jog[w_win];
          r_mem_addr   <= w_addr[w_win];
          r_mem_wdata  <= w_wdata[w_win];
          r_mem_wren   <= w_wren;
          r_gnt[w_win] <= 1'b1;
        end
        ISSUE:   r_cnt <= 3'(RD_LAT - 1);
        WAIT:    if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
        default: ;
      endcase
    end
  end

  // last WAIT cycle: bank q is valid, hand it to the winner's slot
  assign w_ultimo = (r_estado == WAIT) && (r_cnt == 3'd0);

  for (genvar g = 0; g < NC; g++) begin : g_slot
    assign w_load[g] = w_ultimo && (r_win == 2'(g));
    arbitro_memoria_tabuleiro_slot #(.DATA_W(DATA_W)) u_slot (
      .i_clk    (clk),
      .i_rst    (resetGeral),
      .i_load   (w_load[g]),
      .i_data   (w_cap),
      .o_rvalid (w_rvalid[g]),
      .o_rdata  (w_rdata[g])
    );
  end

  assign bus.val_gnt    = r_gnt[0];
  assign bus.col_gnt    = r_gnt[1];
  assign bus.pts_gnt    = r_gnt[2];
  assign bus.vga_gnt    = r_gnt[3];
  assign bus.val_rvalid = w_rvalid[0];
  assign bus.col_rvalid = w_rvalid[1];
  assign bus.pts_rvalid = w_rvalid[2];
  assign bus.vga_rvalid = w_rvalid[3];
  assign bus.val_rdata  = w_rdata[0];
  assign bus.col_rdata  = w_rdata[1];
  assign bus.pts_rdata  = w_rdata[2];
  assign bus.vga_rdata  = w_rdata[3];
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.mem_wren   = r_mem_wren;
endmodule

// File: tb/tb_arbitro_memoria_tabuleiro.sv
// Scoreboard bench: per-client request queues drive the DUT, a decision-level
// reference model predicts grant order, memory effects and read data.
module tb_arbitro_memoria_tabuleiro;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 64;
  localparam int RL = 2;
  localparam int ME = 4;
  localparam int JW = (N > 1) ? $clog2(N) : 1;

  logic clk = 1'b0;
  logic resetGeral;
  always #5 clk = ~clk;

  arbitro_memoria_tabuleiro_if #(.N_JOGADORES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  arbitro_memoria_tabuleiro #(
    .N_JOGADORES(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .MAX_ESPERA(ME)
  ) dut (
    .clk        (clk),
    .resetGeral (resetGeral),
    .bus        (bus)
  );

  typedef struct packed {
    logic          we;
    logic [JW-1:0] jog;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  typedef struct packed {
    int            cli;
    logic          we;
    logic [N-1:0]  wren;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  txn_t pend [4][$];
  exp_t q_gnt[$];
  exp_t q_rsp[$];
  logic [DW-1:0] ref_mem [N][2**AW] = '{default: '0};

  int checks = 0, failures = 0, cyc = 0, rv_cnt = 0, gnt_cnt = 0, vga_idx = 0, last_gnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // board banks: synchronous RAM with RL cycles of read latency
  logic [DW-1:0]   ram [N][2**AW] = '{default: '0};
  logic [N*DW-1:0] rd_pipe [RL];
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) rd_pipe[0][k*DW +: DW] <= ram[k][bus.mem_addr];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    for (int k = 0; k < N; k++) if (bus.mem_wren[k]) ram[k][bus.mem_addr] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = rd_pipe[RL-1];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] gnts();
    return {bus.vga_gnt, bus.pts_gnt, bus.col_gnt, bus.val_gnt};
  endfunction

  // monitor: compare every grant and every response against the scoreboard
  always @(negedge clk) begin
    logic [3:0]    gv, rv;
    exp_t          e;
    logic [DW-1:0] rd;
    gv = gnts();
    rv = {bus.vga_rvalid, bus.pts_rvalid, bus.col_rvalid, bus.val_rvalid};
    if (gv != 4'b0) begin
      gnt_cnt++;
      last_gnt = cyc;
      if (gv[3]) vga_idx = gnt_cnt;
      if (q_gnt.size() == 0) begin
        checks++; failures++;
        $display("FAIL gnt_unexpected: got %b expected none", gv);
      end else begin
        e = q_gnt.pop_front();
        chk("gnt_client", 64'(gv), 64'(4'b0001 << e.cli));
        chk("gnt_wren", 64'(bus.mem_wren), 64'(e.wren));
        chk("gnt_addr", 64'(bus.mem_addr), 64'(e.addr));
        if (e.we) chk("gnt_wdata", bus.mem_wdata, e.data);
      end
    end else if (bus.mem_wren != '0) begin
      checks++; failures++;
      $display("FAIL wren_stray: got %b expected 0", bus.mem_wren);
    end
    if (rv != 4'b0) begin
      rv_cnt++;
      if (q_rsp.size() == 0) begin
        checks++; failures++;
        $display("FAIL rvalid_unexpected: got %b expected none", rv);
      end else begin
        e = q_rsp.pop_front();
        case (e.cli)
          0:       rd = bus.val_rdata;
          1:       rd = bus.col_rdata;
          2:       rd = bus.pts_rdata;
          default: rd = bus.vga_rdata;
        endcase
        chk("rsp_client", 64'(rv), 64'(4'b0001 << e.cli));
        chk("rsp_data", rd, e.data);
        chk("rsp_latency", 64'(cyc - last_gnt), 64'(1 + RL));
      end
    end
  end

  // put client c's head transaction on its request lines (or idle it)
  task automatic drive(input int c);
    txn_t t;
    logic has;
    has = (pend[c].size() != 0);
    t   = has ? pend[c][0] : '0;
    case (c)
      0: begin bus.val_req = has; bus.val_we = t.we; bus.val_jogador = t.jog;
               bus.val_addr = t.addr; bus.val_wdata = t.wdata; end
      1: begin bus.col_req = has; bus.col_we = t.we; bus.col_jogador = t.jog;
               bus.col_addr = t.addr; bus.col_wdata = t.wdata; end
      2: begin bus.pts_req = has; bus.pts_jogador = t.jog; bus.pts_addr = t.addr; end
      default: begin bus.vga_req = has; bus.vga_jogador = t.jog; bus.vga_addr = t.addr; end
    endcase
  endtask

  // reference model: replay the batch decision by decision, updating ref_mem
  task automatic plan();
    int   n[4], ix[4], starve, w;
    txn_t t;
    exp_t e;
    logic ir;
    starve = 0;
    for (int c = 0; c < 4; c++) begin n[c] = pend[c].size(); ix[c] = 0; end
    while (n[0] + n[1] + n[2] + n[3] > 0) begin
      w = -1;
`ifdef ARBITRO_MEM_ANTI_INANICAO_EN
      if (n[3] > 0 && starve == ME) w = 3;
`endif
      for (int c = 0; c < 4; c++) if (w < 0 && n[c] > 0) w = c;
      if (n[3] == 0 || w == 3) starve = 0;
      else if (starve < ME)    starve++;
      t      = pend[w][ix[w]];
      ir     = (int'(t.jog) < N);
      e      = '0;
      e.cli  = w;
      e.we   = t.we;
      e.addr = t.addr;
      if (t.we && ir) e.wren[t.jog] = 1'b1;
      if (t.we) begin
        e.data = t.wdata;
        if (ir) ref_mem[t.jog][t.addr] = t.wdata;
        q_gnt.push_back(e);
      end else begin
        e.data = ir ? ref_mem[t.jog][t.addr] : '0;
        q_gnt.push_back(e);
        q_rsp.push_back(e);
      end
      ix[w]++;
      n[w]--;
    end
  endtask

  task automatic run_batch();
    int left, bound;
    logic [3:0] gv;
    plan();
    @(negedge clk);
    for (int c = 0; c < 4; c++) drive(c);
    bound = 0;
    left  = pend[0].size() + pend[1].size() + pend[2].size() + pend[3].size();
    while (left > 0 && bound < 600) begin
      @(negedge clk);
      bound++;
      gv = gnts();
      for (int c = 0; c < 4; c++)
        if (gv[c] && pend[c].size() != 0) begin
          void'(pend[c].pop_front());
          drive(c);
        end
      left = pend[0].size() + pend[1].size() + pend[2].size() + pend[3].size();
    end
    chk("batch_pending", 64'(left), 64'(0));
    for (int c = 0; c < 4; c++) begin pend[c].delete(); drive(c); end
    repeat (RL + 4) @(negedge clk);
    chk("batch_drain", 64'(q_gnt.size() + q_rsp.size()), 64'(0));
    q_gnt.delete();
    q_rsp.delete();
  endtask

  function automatic txn_t mk(input logic we, input int jog, input int addr, input logic [DW-1:0] d);
    txn_t t;
    t.we = we; t.jog = JW'(jog); t.addr = AW'(addr); t.wdata = d;
    return t;
  endfunction

  function automatic txn_t rnd_txn(input int c);
    logic we;
    we = (c < 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    return mk(we, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), {$urandom, $urandom});
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   base, seen;
    exp_t e;
    resetGeral = 1'b1;
    for (int c = 0; c < 4; c++) drive(c);
    repeat (2) @(negedge clk);
    chk("rst_gnt", 64'(gnts()), 64'(0));
    chk("rst_rvalid", 64'({bus.vga_rvalid, bus.pts_rvalid, bus.col_rvalid, bus.val_rvalid}), 64'(0));
    chk("rst_wren", 64'(bus.mem_wren), 64'(0));
    chk("rst_addr", 64'(bus.mem_addr), 64'(0));
    chk("rst_wdata", bus.mem_wdata, 64'(0));
    chk("rst_val_rdata", bus.val_rdata, 64'(0));
    chk("rst_col_rdata", bus.col_rdata, 64'(0));
    chk("rst_pts_rdata", bus.pts_rdata, 64'(0));
    chk("rst_vga_rdata", bus.vga_rdata, 64'(0));
    resetGeral = 1'b0;

    // col write then read back, bank 1 row 5
    pend[1].push_back(mk(1'b1, 1, 5, 64'hA5));
    pend[1].push_back(mk(1'b0, 1, 5, 64'h0));
    run_batch();

    // val and vga read in the same cycle
    pend[0].push_back(mk(1'b0, 0, 5, 64'h0));
    pend[3].push_back(mk(1'b0, 1, 5, 64'h0));
    run_batch();

    // pts: valid read, then out-of-range bank read; col: out-of-range write
    pend[2].push_back(mk(1'b0, 1, 5, 64'h0));
    pend[2].push_back(mk(1'b0, 3, 5, 64'h0));
    pend[1].push_back(mk(1'b1, 3, 6, 64'hDEAD));
    run_batch();

    // val keeps requesting while vga waits
    for (int i = 0; i < 6; i++) pend[0].push_back(mk(1'b1, i % N, 8 + i, 64'(100 + i)));
    pend[3].push_back(mk(1'b0, 0, 8, 64'h0));
    base = gnt_cnt;
    run_batch();
`ifdef ARBITRO_MEM_ANTI_INANICAO_EN
    chk("vga_decision", 64'(vga_idx - base), 64'(ME + 1));
`else
    chk("vga_decision", 64'(vga_idx - base), 64'(7));
`endif

    // randomized batches
    for (int b = 0; b < 40; b++) begin
      for (int c = 0; c < 4; c++) begin
        int n;
        n = int'($urandom_range(0, 3));
        for (int i = 0; i < n; i++) pend[c].push_back(rnd_txn(c));
      end
      run_batch();
    end

    // reset pulsed while a col read is in WAIT: the read is dropped
    e = '0; e.cli = 1; e.addr = AW'(5);
    q_gnt.push_back(e);
    @(negedge clk);
    pend[1].push_back(mk(1'b0, 1, 5, 64'h0));
    drive(1);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (bus.col_gnt) seen = 1;
    end
    chk("rst_mid_gnt", 64'(seen), 64'(1));
    pend[1].delete();
    drive(1);
    @(negedge clk);
    resetGeral = 1'b1;
    base = rv_cnt;
    @(negedge clk);
    resetGeral = 1'b0;
    repeat (RL + 4) @(negedge clk);
    chk("rst_mid_no_rvalid", 64'(rv_cnt - base), 64'(0));
    chk("rst_mid_col_rdata", bus.col_rdata, 64'(0));
    chk("rst_mid_queue", 64'(q_gnt.size() + q_rsp.size()), 64'(0));
    q_gnt.delete();
    q_rsp.delete();

    // normal service afterwards
    pend[1].push_back(mk(1'b0, 1, 5, 64'h0));
    pend[2].push_back(mk(1'b0, 0, 8, 64'h0));
    run_batch();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
